// File: rtl/cla_seq_adder.sv
// cla_seq_adder
// Adds two WORDS x 4-bit operands with a single 4-bit carry-lookahead slice.
// One nibble is processed per clock, least-significant nibble first.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (has priority over start)
//   start  add request, accepted only in IDLE or DONE
//   a, b   N-bit operands, latched on an accepted start
//   cin    carry into nibble 0, latched on an accepted start
//   busy   high while nibbles are being processed
//   done   one-cycle pulse; sum/cout/ovf are valid in the same cycle
//   sum    registered N-bit result, held until the next done
//   cout   carry out of bit N-1
//   ovf    signed overflow (carry into bit N-1 XOR carry out of bit N-1)
module cla_seq_adder #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*WORDS-1:0] a,
  input  logic [4*WORDS-1:0] b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [4*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int N  = 4 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  acc;
  logic [N-1:0]  acc_next;
  logic          carry;
  logic [IW-1:0] idx;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] s_nib;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  logic accept;
  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start seen in DONE is accepted just like in IDLE, which gives
  // back-to-back operation without an extra idle cycle.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign last = (state == RUN) && (idx == LAST);

  // Pick the current operand nibbles and build the accumulator image with
  // the freshly computed nibble merged in at position idx.
  always_comb begin
    a_nib    = 4'h0;
    b_nib    = 4'h0;
    acc_next = acc;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) begin
        a_nib              = a_reg[4*i +: 4];
        b_nib              = b_reg[4*i +: 4];
        acc_next[4*i +: 4] = s_nib;
      end
    end
  end

  // 4-bit lookahead slice: every carry is expanded directly from G, P and
  // the slice carry-in rather than rippled.
  always_comb begin
    p  = a_nib ^ b_nib;
    g  = a_nib & b_nib;
    c1 = g[0] | (p[0] & carry);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
       | (p[2] & p[1] & p[0] & carry);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry);
    s_nib = p ^ {c3, c2, c1, carry};
  end

  // The result registers are loaded on the last RUN edge so that they are
  // already valid during the DONE cycle; they never move during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      carry <= cin;
      acc   <= '0;
      idx   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_next;
      carry <= c4;
      idx   <= idx + 1'b1;
      if (last) begin
        idx  <= '0;
        sum  <= acc_next;
        cout <= c4;
        ovf  <= c3 ^ c4;
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder with WORDS=4 (16-bit operands).
// Expected results come from a plain arithmetic model and are queued when
// an add is issued; a monitor pops and compares them on every done pulse.
module tb_cla_seq_adder;

  localparam int WORDS = 4;
  localparam int N     = 4 * WORDS;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks;
  int failures;
  int done_count;
  logic prev_done;
  logic [N-1:0] last_sum;

  // {cout, ovf, sum}
  logic [N+1:0] sb[$];

  cla_seq_adder #(.WORDS(WORDS)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic c);
    logic [N:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    v    = (x[N-1] == y[N-1]) && (full[N-1] != x[N-1]);
    return {full[N], v, full[N-1:0]};
  endfunction

  // Scoreboard monitor: compares each done pulse against the oldest queued
  // expectation and watches the done/busy protocol.
  always @(negedge clk) begin
    logic [N+1:0] exp_v;
    if (!rst) begin
      if (done) begin
        done_count++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_done: got done=1 sum=%h required no done", sum);
        end else begin
          exp_v = sb.pop_front();
          if ({cout, ovf, sum} !== exp_v) begin
            failures++;
            $display("[TB] FAIL result: got cout=%b ovf=%b sum=%h required cout=%b ovf=%b sum=%h",
                     cout, ovf, sum, exp_v[N+1], exp_v[N], exp_v[N-1:0]);
          end
        end
        if (busy) begin
          checks++;
          failures++;
          $display("[TB] FAIL done_with_busy: got busy=%b required 0", busy);
        end
        if (prev_done) begin
          checks++;
          failures++;
          $display("[TB] FAIL done_twice: got two consecutive done cycles required one");
        end
      end
    end
    prev_done = done;
  end

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, cout, ovf, sum} !== {4'b0000, {N{1'b0}}}) begin
      failures++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b cout=%b ovf=%b sum=%h required all zero",
               busy, done, cout, ovf, sum);
    end
    rst = 1'b0;
    last_sum = '0;
    @(negedge clk);
  endtask

  // Issue one add from IDLE and check the busy/done timeline inline.
  task automatic run_add(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N+1:0] e;
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    e     = model(x, y, c);
    sb.push_back(e);
    for (int k = 1; k <= WORDS; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || sum !== last_sum) begin
        failures++;
        $display("[TB] FAIL run_cycle%0d: got busy=%b done=%b sum=%h required busy=1 done=0 sum=%h",
                 k, busy, done, sum, last_sum);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_timing: got done=%b busy=%b required done=1 busy=0", done, busy);
    end
    last_sum = e[N-1:0];
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_pulse: got done=%b required 0", done);
    end
  endtask

  task automatic test_basic();
    run_add(16'h1234, 16'h4321, 1'b0);
    run_add(16'hFFFF, 16'h0001, 1'b0);
    run_add(16'hFFFF, 16'h0000, 1'b1);
    run_add(16'h7FFF, 16'h0001, 1'b0);
    run_add(16'h8000, 16'h8000, 1'b0);
    run_add(16'h9ABC, 16'hDEF0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_add(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_ignore_start();
    int d0;
    d0    = done_count;
    a     = 16'h0001;
    b     = 16'h0001;
    cin   = 1'b0;
    start = 1'b1;
    sb.push_back(model(16'h0001, 16'h0001, 1'b0));
    @(negedge clk);
    a     = 16'hAAAA;
    b     = 16'h5555;
    cin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 16'h3C3C;
    b     = 16'hC3C3;
    repeat (10) @(negedge clk);
    checks++;
    if (done_count - d0 != 1) begin
      failures++;
      $display("[TB] FAIL ignore_start_dones: got %0d done pulses required 1", done_count - d0);
    end
    last_sum = 16'h0002;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] xs [5];
    logic [N-1:0] ys [5];
    xs = '{16'h1111, 16'hFFFF, 16'h7FFF, 16'h0F0F, 16'h4000};
    ys = '{16'h2222, 16'h0001, 16'h7FFF, 16'hF0F0, 16'h0ABC};
    start = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b_period%0d: got done=%b required 1", j, done);
        end
      end
      a   = xs[j];
      b   = ys[j];
      cin = 1'b0;
      sb.push_back(model(xs[j], ys[j], 1'b0));
      repeat (WORDS + 1) @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_last: got done=%b required 1", done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL b2b_drain: got busy=%b pending=%0d required busy=0 pending=0",
               busy, sb.size());
    end
    last_sum = 16'h4ABC;
  endtask

  task automatic test_reset_mid_run();
    int d0;
    d0    = done_count;
    a     = 16'h1111;
    b     = 16'h2222;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b required all zero",
               busy, done, sum, cout, ovf);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (done_count != d0) begin
      failures++;
      $display("[TB] FAIL reset_no_done: got %0d done pulses required 0", done_count - d0);
    end
    last_sum = '0;
    run_add(16'h0F0F, 16'h0101, 1'b0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    done_count = 0;
    prev_done  = 1'b0;
    last_sum   = '0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: got %0d pending required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
